// File: rtl/sdes_pkg.sv
// Shared S-DES permutation constants and elaboration-time table helpers.
// Tables are packed as IDX_W-bit entries; entry i names the source bit for output bit i.
package sdes_pkg;

    localparam logic [23:0] SDES_IP_TABLE = 24'hD3B0A9;
    localparam logic        MODE_FWD      = 1'b0;
    localparam logic        MODE_INV      = 1'b1;
    localparam int          TBL_MAX       = 256;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic int tblEntry(input logic [TBL_MAX-1:0] tbl, input int idx, input int idxW);
        logic [TBL_MAX-1:0] shifted;
        logic [TBL_MAX-1:0] mask;
        shifted = tbl >> (idx * idxW);
        mask    = (TBL_MAX'(1) << idxW) - TBL_MAX'(1);
        return int'(shifted & mask);
    endfunction

    // INV[PERM[i]] = i, so routing through INV undoes routing through PERM.
    function automatic logic [TBL_MAX-1:0] inv_table(input logic [TBL_MAX-1:0] perm,
                                                     input int width, input int idxW);
        logic [TBL_MAX-1:0] inv;
        inv = '0;
        for (int i = 0; i < width; i++) begin
            inv = inv | (TBL_MAX'(i) << (tblEntry(perm, i, idxW) * idxW));
        end
        return inv;
    endfunction

    function automatic bit permValid(input logic [TBL_MAX-1:0] perm, input int width, input int idxW);
        logic [TBL_MAX-1:0] seen;
        int entry;
        seen = '0;
        for (int i = 0; i < width; i++) begin
            entry = tblEntry(perm, i, idxW);
            if (entry >= width) begin
                return 1'b0;
            end
            if (seen[entry]) begin
                return 1'b0;
            end
            seen[entry] = 1'b1;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/sdes_perm_net.sv
// Purely combinational bit router: routed[i] = source[TABLE entry i].
// Bit 0 is the MSB on both sides.
module sdes_perm_net
    import sdes_pkg::*;
#(
    parameter int                     WIDTH = 8,
    parameter int                     IDX_W = 3,
    parameter logic [WIDTH*IDX_W-1:0] TABLE = SDES_IP_TABLE
) (
    input  logic [0:WIDTH-1] source,
    output logic [0:WIDTH-1] routed
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : gRoute
            localparam int SRC = int'(TABLE[gi*IDX_W +: IDX_W]);
            assign routed[gi] = source[SRC];
        end
    endgenerate

endmodule

// File: rtl/sdes_perm_stage.sv
// Registered forward/inverse S-DES permutation stage with a 2-entry output buffer.
// Optional SDES_PERM_SELFCHK_EN adds a sticky chk_err round-trip self-check.
module sdes_perm_stage
    import sdes_pkg::*;
#(
    parameter int                     WIDTH = 8,
    parameter int                     IDX_W = 3,
    parameter logic [WIDTH*IDX_W-1:0] PERM  = SDES_IP_TABLE,
    parameter int                     CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [0:WIDTH-1] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [0:WIDTH-1] out_data,
    output logic [CNT_W-1:0] beat_cnt
`ifdef SDES_PERM_SELFCHK_EN
    ,
    output logic             chk_err
`endif
);

    localparam logic [TBL_MAX-1:0]     INV_FULL = inv_table(TBL_MAX'(PERM), WIDTH, IDX_W);
    localparam logic [WIDTH*IDX_W-1:0] INV      = INV_FULL[WIDTH*IDX_W-1:0];

    generate
        if (WIDTH * IDX_W > TBL_MAX || clog2(WIDTH) > IDX_W ||
            !permValid(TBL_MAX'(PERM), WIDTH, IDX_W)) begin : gBadPerm
            $fatal(1, "sdes_perm_stage: PERM is not a valid permutation of WIDTH bits");
        end
    endgenerate

    logic [0:WIDTH-1] fwdIn;
    logic [0:WIDTH-1] fwdOut;
    logic [0:WIDTH-1] invOut;
    logic [0:WIDTH-1] pushData;

    sdes_perm_net #(.WIDTH(WIDTH), .IDX_W(IDX_W), .TABLE(PERM)) uFwd (
        .source(fwdIn),
        .routed(fwdOut)
    );

    sdes_perm_net #(.WIDTH(WIDTH), .IDX_W(IDX_W), .TABLE(INV)) uInv (
        .source(in_data),
        .routed(invOut)
    );

    assign pushData = (in_mode == MODE_INV) ? invOut : fwdOut;

    // slot0 is always the head; slot1 only holds data when count == 2.
    logic [1:0]       count, countNext;
    logic [0:WIDTH-1] slot0Data, slot0DataNext;
    logic [0:WIDTH-1] slot1Data, slot1DataNext;
    logic             slot0Mode, slot0ModeNext;
    logic             slot1Mode, slot1ModeNext;
    logic             inReady, inReadyNext;
    logic [CNT_W-1:0] beatCnt, beatCntNext;
    logic             push, pop;

    assign push = in_valid & inReady;
    assign pop  = (count != 2'd0) & out_ready;

    always_comb begin
        countNext     = count;
        slot0DataNext = slot0Data;
        slot0ModeNext = slot0Mode;
        slot1DataNext = slot1Data;
        slot1ModeNext = slot1Mode;
        beatCntNext   = beatCnt;
        if (flush) begin
            countNext = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0DataNext = pushData;
                        slot0ModeNext = in_mode;
                    end else begin
                        slot1DataNext = pushData;
                        slot1ModeNext = in_mode;
                    end
                    countNext = count + 2'd1;
                end
                2'b01: begin
                    slot0DataNext = slot1Data;
                    slot0ModeNext = slot1Mode;
                    countNext     = count - 2'd1;
                end
                // Only reachable at count 1: push is blocked at 2, pop at 0.
                2'b11: begin
                    slot0DataNext = pushData;
                    slot0ModeNext = in_mode;
                end
                default: begin
                end
            endcase
            if (pop) begin
                beatCntNext = beatCnt + CNT_W'(1);
            end
        end
        // Ready is a pure function of next-state, so out_ready never reaches in_ready combinationally.
        inReadyNext = !flush && (countNext != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            slot0Data <= '0;
            slot0Mode <= 1'b0;
            slot1Data <= '0;
            slot1Mode <= 1'b0;
            inReady   <= 1'b0;
            beatCnt   <= '0;
        end else begin
            count     <= countNext;
            slot0Data <= slot0DataNext;
            slot0Mode <= slot0ModeNext;
            slot1Data <= slot1DataNext;
            slot1Mode <= slot1ModeNext;
            inReady   <= inReadyNext;
            beatCnt   <= beatCntNext;
        end
    end

    assign in_ready  = inReady;
    assign out_valid = (count != 2'd0);
    assign out_mode  = slot0Mode;
    assign out_data  = slot0Data;
    assign beat_cnt  = beatCnt;

`ifdef SDES_PERM_SELFCHK_EN
    // In inverse mode the forward net re-applies PERM to the inverse result,
    // giving the round trip; in forward mode a third (inverse) net does it.
    logic [0:WIDTH-1] chkInv;
    logic [0:WIDTH-1] checkData;
    logic             chkErr;

    assign fwdIn = (in_mode == MODE_INV) ? invOut : in_data;

    sdes_perm_net #(.WIDTH(WIDTH), .IDX_W(IDX_W), .TABLE(INV)) uChk (
        .source(fwdOut),
        .routed(chkInv)
    );

    assign checkData = (in_mode == MODE_INV) ? fwdOut : chkInv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chkErr <= 1'b0;
        end else if (push && (checkData != in_data)) begin
            chkErr <= 1'b1;
        end
    end

    assign chk_err = chkErr;
`else
    assign fwdIn = in_data;
`endif

endmodule

// File: tb/tb_sdes_perm_stage.sv
// Scoreboard bench for sdes_perm_stage: expected beats are queued at push and
// compared at pop; CNT_W=4 so the beat counter wrap is reachable.
module tb_sdes_perm_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_mode = 1'b0;
    logic [0:7] in_data = '0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic       out_mode;
    logic [0:7] out_data;
    logic [3:0] beat_cnt;
`ifdef SDES_PERM_SELFCHK_EN
    logic       chk_err;
`endif

    sdes_perm_stage #(.WIDTH(8), .IDX_W(3), .PERM(24'hD3B0A9), .CNT_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_mode(in_mode),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mode(out_mode),
        .out_data(out_data),
        .beat_cnt(beat_cnt)
`ifdef SDES_PERM_SELFCHK_EN
        ,
        .chk_err(chk_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mode;
        logic [0:7] data;
    } beat_t;

    beat_t      sb[$];
    int         checks = 0;
    int         errors = 0;
    int         pushes = 0;
    int         stalls = 0;
    logic [0:7] nextExp = '0;
    logic [3:0] expCnt = '0;
    int         ipTab[8] = '{1, 5, 2, 0, 3, 7, 4, 6};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Independent reference: the S-DES IP written out as a plain index list.
    function automatic logic [0:7] model(input logic [0:7] x, input logic inv);
        logic [0:7] y;
        y = '0;
        for (int i = 0; i < 8; i++) begin
            if (inv) y[ipTab[i]] = x[i];
            else     y[i] = x[ipTab[i]];
        end
        return y;
    endfunction

    // One clock: predict the edge at the negedge, then verify state just after it.
    task automatic cycle();
        logic  doPush;
        logic  doPop;
        logic  expReady;
        beat_t e;
        @(negedge clk);
        doPush = in_valid && in_ready;
        doPop  = out_valid && out_ready;
        if (in_valid && !in_ready) stalls++;
        if (doPop) begin
            if (sb.size() == 0) begin
                check("spurious_beat", 32'(out_valid), 32'(0));
            end else begin
                e = sb.pop_front();
                check("beat", 32'({out_mode, out_data}), 32'(e));
                $display("beat out: mode=%0d data=%02h cnt=%0d", out_mode, out_data, beat_cnt);
            end
            if (!flush) expCnt = expCnt + 4'd1;
        end
        if (doPush) begin
            sb.push_back({in_mode, nextExp});
            pushes++;
        end
        if (flush) sb.delete();
        expReady = !flush && (sb.size() < 2);
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        check("beat_cnt", 32'(beat_cnt), 32'(expCnt));
        check("in_ready", 32'(in_ready), 32'(expReady));
    endtask

    task automatic drive(input logic [0:7] d, input logic m);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        nextExp  = model(d, m);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 8 && sb.size() != 0; t++) cycle();
        check("drain_empty", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [0:7] held;
        logic [0:7] orig;
        logic [3:0] cntBefore;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_out_mode", 32'(out_mode), 32'(0));
        check("rst_beat_cnt", 32'(beat_cnt), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", 32'(in_ready), 32'(1));

        // Forward and inverse single beats against known constants.
        out_ready = 1'b1;
        drive(8'hA5, 1'b0);
        cycle();
        in_valid = 1'b0;
        check("fwd_data", 32'(out_data), 32'h74);
        check("fwd_mode", 32'(out_mode), 32'(0));
        cycle();
        check("fwd_cnt", 32'(beat_cnt), 32'(1));
        drive(8'h74, 1'b1);
        cycle();
        in_valid = 1'b0;
        check("inv_data", 32'(out_data), 32'hA5);
        check("inv_mode", 32'(out_mode), 32'(1));
        cycle();

        // Back-to-back alternating modes; inverse beats must return the original value.
        stalls = 0;
        pushes = 0;
        for (int k = 0; k < 256; k++) begin
            orig = 8'(k);
            drive(orig, 1'b0);
            cycle();
            drive(model(orig, 1'b0), 1'b1);
            nextExp = orig;
            cycle();
        end
        in_valid = 1'b0;
        check("rt_stalls", 32'(stalls), 32'(0));
        check("rt_pushes", 32'(pushes), 32'(512));
        drain();

        // Backpressure: third beat must be refused and the head held.
        out_ready = 1'b0;
        pushes = 0;
        held = '0;
        for (int b = 0; b < 3; b++) begin
            drive(8'(8'h11 * (b + 1)), 1'(b));
            cycle();
            if (b == 0) held = out_data;
        end
        check("bp_accepted", 32'(pushes), 32'(2));
        check("bp_ready_low", 32'(in_ready), 32'(0));
        check("bp_stable", 32'(out_data), 32'(held));
        check("bp_head", 32'(out_data), 32'(model(8'h11, 1'b0)));
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        check("bp_ready_back", 32'(in_ready), 32'(1));
        drain();

        // Flush while full with a push and pop requested.
        out_ready = 1'b0;
        drive(8'h3C, 1'b0);
        cycle();
        drive(8'hC3, 1'b1);
        cycle();
        cntBefore = beat_cnt;
        drive(8'h5A, 1'b0);
        flush = 1'b1;
        out_ready = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 32'(0));
        check("flush_cnt", 32'(beat_cnt), 32'(cntBefore));
        cycle();
        check("flush_ready_back", 32'(in_ready), 32'(1));

        // Flush at count 1 discards a beat accepted in the same cycle.
        out_ready = 1'b0;
        drive(8'h0F, 1'b0);
        cycle();
        drive(8'hF0, 1'b1);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush1_valid", 32'(out_valid), 32'(0));
        cycle();

        // Asynchronous reset between clock edges with a beat buffered.
        drive(8'h96, 1'b1);
        cycle();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'(0));
        check("arst_out_data", 32'(out_data), 32'(0));
        check("arst_out_mode", 32'(out_mode), 32'(0));
        check("arst_beat_cnt", 32'(beat_cnt), 32'(0));
        check("arst_in_ready", 32'(in_ready), 32'(0));
        sb.delete();
        expCnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_ready_back", 32'(in_ready), 32'(1));

        // Counter wrap: 17 beats through a 4-bit counter.
        out_ready = 1'b1;
        for (int w = 0; w < 17; w++) begin
            drive(8'(w * 37 + 5), 1'(w % 2));
            cycle();
        end
        drain();
        check("wrap_cnt", 32'(beat_cnt), 32'(1));

`ifdef SDES_PERM_SELFCHK_EN
        check("chk_clean", 32'(chk_err), 32'(0));
        out_ready = 1'b0;
        force dut.uChk.routed = 8'h00;
        drive(8'hA5, 1'b0);
        cycle();
        in_valid = 1'b0;
        release dut.uChk.routed;
        check("chk_set", 32'(chk_err), 32'(1));
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("chk_sticky", 32'(chk_err), 32'(1));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
